// File: rtl/ram_transfer_sequencer.sv
// Sequences the shared account RAM for one coin transfer: key check, funds and
// headroom checks, then writes both balances. All outputs are registered.
module ram_transfer_sequencer #(
   parameter int READ_LATENCY = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic       sender,
   input  logic [7:0] amount,
   input  logic [7:0] key,
   input  logic [7:0] ram_result,
   output logic       ram_access_p2,
   output logic [1:0] ram_access_type,
   output logic [7:0] ram_data_in,
   output logic       ram_wren,
   output logic       busy,
   output logic       done,
   output logic [1:0] status,
   output logic [2:0] step
);

   typedef enum logic [2:0] {
      IDLE, RD_KEY, RD_SBAL, RD_RBAL, CHECK, WR_SBAL, WR_RBAL, DONE
   } state_t;

   localparam logic [1:0] LAT     = 2'(READ_LATENCY);
   localparam logic [1:0] ST_OK   = 2'b00;
   localparam logic [1:0] ST_KEY  = 2'b01;
   localparam logic [1:0] ST_FUND = 2'b10;
   localparam logic [1:0] ST_OVF  = 2'b11;
   localparam logic [1:0] F_BAL   = 2'b00;
   localparam logic [1:0] F_KEY   = 2'b01;

   state_t     state_q, state_d;
   logic [1:0] cnt_q, cnt_d;
   logic       sender_q, sender_d;
   logic [7:0] amount_q, amount_d, key_q, key_d;
   logic [7:0] sbal_q, sbal_d, rbal_q, rbal_d;
   logic [1:0] status_q, status_d;
   logic       p2_q, p2_d, wren_q, wren_d, busy_q, busy_d, done_q, done_d;
   logic [1:0] type_q, type_d;
   logic [7:0] data_q, data_d;
   logic [2:0] step_q, step_d;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sender_d = sender_q;
      amount_d = amount_q;
      key_d    = key_q;
      sbal_d   = sbal_q;
      rbal_d   = rbal_q;
      status_d = status_q;
      case (state_q)
         IDLE: if (start) begin
            sender_d = sender;
            amount_d = amount;
            key_d    = key;
            status_d = ST_OK;
            cnt_d    = 2'd0;
            state_d  = RD_KEY;
         end
         RD_KEY: if (cnt_q == LAT) begin
            cnt_d = 2'd0;
            if (ram_result != key_q) begin
               status_d = ST_KEY;
               state_d  = DONE;
            end else begin
               state_d = RD_SBAL;
            end
         end else cnt_d = cnt_q + 2'd1;
         RD_SBAL: if (cnt_q == LAT) begin
            cnt_d   = 2'd0;
            sbal_d  = ram_result;
            state_d = RD_RBAL;
         end else cnt_d = cnt_q + 2'd1;
         RD_RBAL: if (cnt_q == LAT) begin
            cnt_d   = 2'd0;
            rbal_d  = ram_result;
            state_d = CHECK;
         end else cnt_d = cnt_q + 2'd1;
         CHECK: begin
            // funds shortfall takes priority over receiver overflow
            if (sbal_q < amount_q) begin
               status_d = ST_FUND;
               state_d  = DONE;
            end else if (({1'b0, rbal_q} + {1'b0, amount_q}) > 9'd255) begin
               status_d = ST_OVF;
               state_d  = DONE;
            end else begin
               state_d = WR_SBAL;
            end
         end
         WR_SBAL: state_d = WR_RBAL;
         WR_RBAL: state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they line up with it once registered.
   always_comb begin
      p2_d   = 1'b0;
      type_d = F_BAL;
      data_d = 8'd0;
      wren_d = 1'b0;
      done_d = 1'b0;
      step_d = 3'd0;
      busy_d = (state_d != IDLE);
      case (state_d)
         RD_KEY:  begin p2_d = sender_d;  type_d = F_KEY; step_d = 3'd1; end
         RD_SBAL: begin p2_d = sender_d;  step_d = 3'd2; end
         RD_RBAL: begin p2_d = ~sender_d; step_d = 3'd3; end
         CHECK:   begin p2_d = ~sender_d; step_d = 3'd3; end
         WR_SBAL: begin
            p2_d   = sender_d;
            data_d = sbal_q - amount_q;
            wren_d = 1'b1;
            step_d = 3'd4;
         end
         WR_RBAL: begin
            p2_d   = ~sender_d;
            data_d = rbal_q + amount_q;
            wren_d = 1'b1;
            step_d = 3'd4;
         end
         DONE:    begin done_d = 1'b1; step_d = 3'd5; end
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= 2'd0;
         sender_q <= 1'b0;
         amount_q <= 8'd0;
         key_q    <= 8'd0;
         sbal_q   <= 8'd0;
         rbal_q   <= 8'd0;
         status_q <= ST_OK;
         p2_q     <= 1'b0;
         type_q   <= F_BAL;
         data_q   <= 8'd0;
         wren_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         step_q   <= 3'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         sender_q <= sender_d;
         amount_q <= amount_d;
         key_q    <= key_d;
         sbal_q   <= sbal_d;
         rbal_q   <= rbal_d;
         status_q <= status_d;
         p2_q     <= p2_d;
         type_q   <= type_d;
         data_q   <= data_d;
         wren_q   <= wren_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         step_q   <= step_d;
      end
   end

   assign ram_access_p2   = p2_q;
   assign ram_access_type = type_q;
   assign ram_data_in     = data_q;
   assign ram_wren        = wren_q;
   assign busy            = busy_q;
   assign done            = done_q;
   assign status          = status_q;
   assign step            = step_q;

endmodule
